snake_asset_io: RTL and testbench

- Front-end utility block for the snake game top level.
- Debounces the four user push-buttons and produces clean levels plus one-cycle press pulses.
- Hosts two single-port synchronous image memories, 12-bit RGB444 per word:
  - cover: the 320x240 title screen.
  - lose: the 64x80 "game over" banner.
- All logic runs on one clock; the VGA/FSM logic reads the memories through their address ports.

---
 rtl/snake_asset_io.sv | 154 +++++++++++++++
 tb/tb_snake_asset_io.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_asset_io.sv
// Front-end I/O for the snake top level: per-button debounce with press pulses,
// plus the cover (title screen) and lose (banner) RGB444 image memories.

module snake_asset_io_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pressed
);
    localparam int CW = 24;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          prev_level;

    // The counter only runs while the synchronized sample disagrees with the
    // committed level; any agreement restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync       <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            prev_level <= 1'b0;
        end else begin
            sync       <= {sync[0], raw};
            prev_level <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pressed = level & ~prev_level;
endmodule

module snake_asset_io_ram #(
    parameter int    DATA_WIDTH = 12,
    parameter int    ADDR_WIDTH = 18,
    parameter int    SIZE       = 5120,
    parameter string INIT       = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [DATA_WIDTH-1:0] mem [0:SIZE-1];
    logic [IW-1:0]         idx;
    logic                  hit;

    // Full address is range-checked so aliases above SIZE never reach the array.
    assign idx = addr[IW-1:0];
    assign hit = (addr < ADDR_WIDTH'(SIZE));

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (en && we && hit) mem[idx] <= din;
    end

    // Read happens on writes too, giving the pre-write contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (en) begin
            dout <= hit ? mem[idx] : '0;
        end
    end
endmodule

module snake_asset_io #(
    parameter int    NUM_BTN    = 4,
    parameter int    DB_CYCLES  = 1000000,
    parameter int    DATA_WIDTH = 12,
    parameter int    ADDR_WIDTH = 18,
    parameter int    COVER_SIZE = 76800,
    parameter int    LOSE_SIZE  = 5120,
    parameter string COVER_INIT = "",
    parameter string LOSE_INIT  = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_BTN-1:0]    btn_in,
    output logic [NUM_BTN-1:0]    btn_level,
    output logic [NUM_BTN-1:0]    btn_pressed,
    input  logic                  cover_en,
    input  logic                  cover_we,
    input  logic [ADDR_WIDTH-1:0] cover_addr,
    input  logic [DATA_WIDTH-1:0] cover_din,
    output logic [DATA_WIDTH-1:0] cover_dout,
    input  logic                  lose_en,
    input  logic                  lose_we,
    input  logic [ADDR_WIDTH-1:0] lose_addr,
    input  logic [DATA_WIDTH-1:0] lose_din,
    output logic [DATA_WIDTH-1:0] lose_dout
);
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        snake_asset_io_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (btn_in[g]),
            .level   (btn_level[g]),
            .pressed (btn_pressed[g])
        );
    end

    snake_asset_io_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE       (COVER_SIZE),
        .INIT       (COVER_INIT)
    ) u_cover (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cover_en),
        .we      (cover_we),
        .addr    (cover_addr),
        .din     (cover_din),
        .dout    (cover_dout)
    );

    snake_asset_io_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE       (LOSE_SIZE),
        .INIT       (LOSE_INIT)
    ) u_lose (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (lose_en),
        .we      (lose_we),
        .addr    (lose_addr),
        .din     (lose_din),
        .dout    (lose_dout)
    );
endmodule

// File: tb/tb_snake_asset_io.sv
// Directed bench for snake_asset_io: debounce timing, press pulses, memory access rules, reset.

module tb_snake_asset_io;
    logic        clk;
    logic        reset_n;
    logic [3:0]  btn_in;
    logic [3:0]  btn_level;
    logic [3:0]  btn_pressed;
    logic        cover_en, cover_we, lose_en, lose_we;
    logic [17:0] cover_addr, lose_addr;
    logic [11:0] cover_din, lose_din, cover_dout, lose_dout;

    int checks = 0;
    int errors = 0;

    snake_asset_io #(
        .NUM_BTN   (4),
        .DB_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_pressed (btn_pressed),
        .cover_en    (cover_en),
        .cover_we    (cover_we),
        .cover_addr  (cover_addr),
        .cover_din   (cover_din),
        .cover_dout  (cover_dout),
        .lose_en     (lose_en),
        .lose_we     (lose_we),
        .lose_addr   (lose_addr),
        .lose_din    (lose_din),
        .lose_dout   (lose_dout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input logic ce, input logic cw, input logic [17:0] ca, input logic [11:0] cd,
                          input logic le, input logic lw, input logic [17:0] la, input logic [11:0] ld);
        cover_en = ce; cover_we = cw; cover_addr = ca; cover_din = cd;
        lose_en = le;  lose_we = lw;  lose_addr = la;  lose_din = ld;
        step();
        cover_en = 0; cover_we = 0; lose_en = 0; lose_we = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; btn_in = 4'hF;
        cover_en = 0; cover_we = 0; cover_addr = 0; cover_din = 0;
        lose_en = 0;  lose_we = 0;  lose_addr = 0;  lose_din = 0;
        repeat (4) step();
        checks++;
        if (btn_level !== 4'h0) begin errors++; $display("FAIL reset_level got %h exp 0", btn_level); end
        checks++;
        if (btn_pressed !== 4'h0) begin errors++; $display("FAIL reset_pressed got %h exp 0", btn_pressed); end
        checks++;
        if (cover_dout !== 12'h000 || lose_dout !== 12'h000) begin
            errors++; $display("FAIL reset_dout got %h/%h exp 000/000", cover_dout, lose_dout);
        end
        btn_in = 4'h0;
        reset_n = 1;
        repeat (3) step();
    endtask

    task automatic test_debounce_latency();
        btn_in[0] = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i < 10) begin
                checks++;
                if (btn_level[0] !== 1'b0) begin errors++; $display("FAIL db_early edge %0d got 1 exp 0", i); end
            end else begin
                checks++;
                if (btn_level !== 4'b0001) begin errors++; $display("FAIL db_rise got %b exp 0001", btn_level); end
                checks++;
                if (btn_pressed !== 4'b0001) begin errors++; $display("FAIL db_pulse got %b exp 0001", btn_pressed); end
            end
        end
        step();
        checks++;
        if (btn_pressed !== 4'b0000 || btn_level !== 4'b0001) begin
            errors++; $display("FAIL db_pulse_end got p=%b l=%b exp p=0000 l=0001", btn_pressed, btn_level);
        end
    endtask

    task automatic test_glitch_and_release();
        logic seen;
        seen = 0;
        btn_in[2] = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (btn_level[2] || btn_pressed[2]) seen = 1;
        end
        btn_in[2] = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (btn_level[2] || btn_pressed[2]) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL glitch got seen=1 exp 0"); end
        seen = 0;
        btn_in[0] = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (btn_pressed !== 4'b0000) seen = 1;
            if (i == 9) begin
                checks++;
                if (btn_level[0] !== 1'b1) begin errors++; $display("FAIL release_early got 0 exp 1"); end
            end
        end
        checks++;
        if (btn_level !== 4'b0000) begin errors++; $display("FAIL release_fall got %b exp 0000", btn_level); end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL release_pulse got pulse exp none"); end
    endtask

    task automatic test_mem_rw();
        mem_op(1, 1, 18'd76799, 12'hABC, 1, 1, 18'd5119, 12'h123);
        checks++;
        if (cover_dout !== 12'h000 || lose_dout !== 12'h000) begin
            errors++; $display("FAIL wr_old got %h/%h exp 000/000", cover_dout, lose_dout);
        end
        cover_en = 1; cover_addr = 18'd76799; lose_en = 1; lose_addr = 18'd5119;
        #2;
        checks++;
        if (cover_dout !== 12'h000) begin errors++; $display("FAIL rd_latency got %h exp 000", cover_dout); end
        step();
        cover_en = 0; lose_en = 0;
        checks++;
        if (cover_dout !== 12'hABC || lose_dout !== 12'h123) begin
            errors++; $display("FAIL rd_back got %h/%h exp ABC/123", cover_dout, lose_dout);
        end
    endtask

    task automatic test_boundary_enable();
        mem_op(1, 1, 18'd76800, 12'hFFF, 1, 1, 18'd5120, 12'hFFF);
        checks++;
        if (cover_dout !== 12'h000 || lose_dout !== 12'h000) begin
            errors++; $display("FAIL oob_wr_dout got %h/%h exp 000/000", cover_dout, lose_dout);
        end
        mem_op(1, 0, 18'd76799, 12'h0, 1, 0, 18'd5119, 12'h0);
        mem_op(1, 0, 18'd76800, 12'h0, 1, 0, 18'd5120, 12'h0);
        checks++;
        if (cover_dout !== 12'h000 || lose_dout !== 12'h000) begin
            errors++; $display("FAIL oob_rd got %h/%h exp 000/000", cover_dout, lose_dout);
        end
        // Aliases whose low bits hit the last valid words
        mem_op(1, 0, 18'd76799, 12'h0, 1, 0, 18'd5119, 12'h0);
        mem_op(1, 0, 18'd207871, 12'h0, 1, 0, 18'd13311, 12'h0);
        checks++;
        if (cover_dout !== 12'h000 || lose_dout !== 12'h000) begin
            errors++; $display("FAIL alias_rd got %h/%h exp 000/000", cover_dout, lose_dout);
        end
        mem_op(1, 0, 18'd76799, 12'h0, 1, 0, 18'd5119, 12'h0);
        mem_op(0, 1, 18'd0, 12'h777, 0, 1, 18'd0, 12'h777);
        checks++;
        if (cover_dout !== 12'hABC || lose_dout !== 12'h123) begin
            errors++; $display("FAIL en_hold got %h/%h exp ABC/123", cover_dout, lose_dout);
        end
        mem_op(1, 0, 18'd0, 12'h0, 1, 0, 18'd0, 12'h0);
        checks++;
        if (cover_dout !== 12'h000 || lose_dout !== 12'h000) begin
            errors++; $display("FAIL en0_nowrite got %h/%h exp 000/000", cover_dout, lose_dout);
        end
        mem_op(1, 1, 18'd76799, 12'h555, 0, 0, 18'd0, 12'h0);
        checks++;
        if (cover_dout !== 12'hABC) begin errors++; $display("FAIL rbw_old got %h exp ABC", cover_dout); end
        mem_op(1, 0, 18'd76799, 12'h0, 0, 0, 18'd0, 12'h0);
        checks++;
        if (cover_dout !== 12'h555) begin errors++; $display("FAIL rbw_new got %h exp 555", cover_dout); end
        mem_op(1, 1, 18'd76799, 12'hABC, 0, 0, 18'd0, 12'h0);
    endtask

    task automatic test_reset_midop();
        btn_in[1] = 1;
        repeat (12) step();
        mem_op(1, 0, 18'd76799, 12'h0, 0, 0, 18'd0, 12'h0);
        checks++;
        if (btn_level[1] !== 1'b1 || cover_dout !== 12'hABC) begin
            errors++; $display("FAIL midop_pre got l=%b d=%h exp 1/ABC", btn_level[1], cover_dout);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if (btn_level !== 4'h0 || cover_dout !== 12'h000) begin
            errors++; $display("FAIL midop_async got l=%b d=%h exp 0000/000", btn_level, cover_dout);
        end
        btn_in = 4'h0;
        step();
        reset_n = 1;
        step();
        mem_op(1, 0, 18'd76799, 12'h0, 0, 0, 18'd0, 12'h0);
        checks++;
        if (cover_dout !== 12'hABC) begin errors++; $display("FAIL mem_kept got %h exp ABC", cover_dout); end
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_glitch_and_release();
        test_mem_rw();
        test_boundary_enable();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
